// File: rtl/ball_mover_if.sv
// Handshake bundle between the playfield controller and ball_mover.
// The slave side is the mover itself; the master side drives frame/serve/collision inputs.
interface ball_mover_if;
  logic       frame_tick;
  logic       serve;
  logic       collide_l;
  logic       collide_r;
  logic [9:0] deflect;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_play;
  logic       goal_l;
  logic       goal_r;

  modport master (
    output frame_tick, serve, collide_l, collide_r, deflect,
    input  ball_x, ball_y, in_play, goal_l, goal_r
  );

  modport slave (
    input  frame_tick, serve, collide_l, collide_r, deflect,
    output ball_x, ball_y, in_play, goal_l, goal_r
  );
endinterface

// File: rtl/ball_mover.sv
// Ball position/velocity owner: per-frame motion, wall bounces, paddle returns, goals, serve/hold.
// Optional macro BALL_SPEEDUP_EN: each accepted paddle hit bumps horizontal speed up to MAX_DX.
module ball_mover #(
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int BALL_SIZE   = 8,
  parameter int XSPEED      = 4,
  parameter int DEFL_SHIFT  = 2,
  parameter int MAX_DY      = 8,
  parameter int MAX_DX      = 8,
  parameter int HOLD_FRAMES = 60
) (
  input logic        clk,
  input logic        reset_n,
  ball_mover_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_SCORED = 2'd2;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  localparam int X_LIM    = FIELD_W - BALL_SIZE;
  localparam int Y_LIM    = FIELD_H - BALL_SIZE;
  // dx register is sized for whichever of serve speed and ceiling is larger
  localparam int DX_CEIL  = (MAX_DX > XSPEED) ? MAX_DX : XSPEED;
  localparam int DX_W     = $clog2(DX_CEIL + 1);
  localparam int DY_W     = $clog2(MAX_DY + 1);
  localparam int HOLD_W   = $clog2(HOLD_FRAMES + 1);

  localparam logic        [9:0]        X_MAX   = 10'(X_LIM);
  localparam logic        [9:0]        Y_MAX   = 10'(Y_LIM);
  localparam logic        [9:0]        X_CTR   = 10'(X_LIM / 2);
  localparam logic        [9:0]        Y_CTR   = 10'(Y_LIM / 2);
  localparam logic signed [10:0]       X_MAX_S = 11'(X_LIM);
  localparam logic signed [10:0]       Y_MAX_S = 11'(Y_LIM);
  localparam logic        [DX_W-1:0]   DX_SRV  = DX_W'(XSPEED);
  localparam logic        [DY_W-1:0]   DY_CAP  = DY_W'(MAX_DY);
  localparam logic        [8:0]        DY_CAP9 = 9'(MAX_DY);
  localparam logic        [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  logic [1:0]        state, state_n;
  logic              dx_dir, dir_n, dir_v;
  logic [DX_W-1:0]   dx, dx_n, dx_v;
  logic [DY_W-1:0]   dy, dy_n, dy_v, dy_hit;
  logic              dy_up, up_n, up_v;
  logic [9:0]        x_q, x_n, y_q, y_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              gl_q, gl_n, gr_q, gr_n, in_play_q;
  logic              cl_q, cr_q;
  logic              hit_l, hit_r, hit;
  logic [8:0]        defl_mag;
  logic signed [10:0] dx_s, dy_s, nx, ny;

  // Rising-edge capture, gated by travel direction so a ball still inside
  // the paddle cannot be returned twice.
  assign hit_l = bus.collide_l & ~cl_q & (state == S_PLAY) & (dx_dir == DIR_L);
  assign hit_r = bus.collide_r & ~cr_q & (state == S_PLAY) & (dx_dir == DIR_R);
  assign hit   = hit_l | hit_r;

  assign defl_mag = bus.deflect[8:0] >> DEFL_SHIFT;
  assign dy_hit   = (defl_mag > DY_CAP9) ? DY_CAP : defl_mag[DY_W-1:0];

  // Velocity after any same-cycle hit; the motion step below uses it directly.
  assign dir_v = hit ? ~dx_dir : dx_dir;
  assign dy_v  = hit ? dy_hit : dy;
  assign up_v  = hit ? bus.deflect[9] : dy_up;
`ifdef BALL_SPEEDUP_EN
  assign dx_v  = !hit ? dx : ((dx >= DX_W'(MAX_DX)) ? DX_W'(MAX_DX) : dx + 1'b1);
`else
  assign dx_v  = dx;
`endif

  assign dx_s = 11'(dx_v);
  assign dy_s = 11'(dy_v);
  assign nx   = (dir_v == DIR_L) ? $signed({1'b0, x_q}) - dx_s : $signed({1'b0, x_q}) + dx_s;
  assign ny   = up_v ? $signed({1'b0, y_q}) - dy_s : $signed({1'b0, y_q}) + dy_s;

  always_comb begin
    state_n = state;
    dir_n   = dx_dir;
    dx_n    = dx;
    dy_n    = dy;
    up_n    = dy_up;
    x_n     = x_q;
    y_n     = y_q;
    hold_n  = hold_cnt;
    gl_n    = 1'b0;
    gr_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.serve) begin
          state_n = S_PLAY;
          dx_n    = DX_SRV;
          dy_n    = '0;
        end
      end
      S_PLAY: begin
        dir_n = dir_v;
        dx_n  = dx_v;
        dy_n  = dy_v;
        up_n  = up_v;
        if (bus.frame_tick) begin
          if (ny < 0) begin
            y_n  = '0;
            up_n = 1'b0;
          end else if (ny > Y_MAX_S) begin
            y_n  = Y_MAX;
            up_n = 1'b1;
          end else begin
            y_n  = ny[9:0];
          end
          // A miss sends the next serve toward the player who conceded.
          if (nx <= 0) begin
            x_n     = '0;
            gr_n    = 1'b1;
            state_n = S_SCORED;
            dir_n   = DIR_L;
            hold_n  = '0;
          end else if (nx >= X_MAX_S) begin
            x_n     = X_MAX;
            gl_n    = 1'b1;
            state_n = S_SCORED;
            dir_n   = DIR_R;
            hold_n  = '0;
          end else begin
            x_n     = nx[9:0];
          end
        end
      end
      S_SCORED: begin
        if (bus.frame_tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_n = S_IDLE;
            x_n     = X_CTR;
            y_n     = Y_CTR;
          end else begin
            hold_n  = hold_cnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      dx_dir    <= DIR_R;
      dx        <= DX_SRV;
      dy        <= '0;
      dy_up     <= 1'b0;
      x_q       <= X_CTR;
      y_q       <= Y_CTR;
      hold_cnt  <= '0;
      gl_q      <= 1'b0;
      gr_q      <= 1'b0;
      in_play_q <= 1'b0;
      cl_q      <= 1'b0;
      cr_q      <= 1'b0;
    end else begin
      state     <= state_n;
      dx_dir    <= dir_n;
      dx        <= dx_n;
      dy        <= dy_n;
      dy_up     <= up_n;
      x_q       <= x_n;
      y_q       <= y_n;
      hold_cnt  <= hold_n;
      gl_q      <= gl_n;
      gr_q      <= gr_n;
      in_play_q <= (state_n == S_PLAY);
      cl_q      <= bus.collide_l;
      cr_q      <= bus.collide_r;
    end
  end

  assign bus.ball_x  = x_q;
  assign bus.ball_y  = y_q;
  assign bus.in_play = in_play_q;
  assign bus.goal_l  = gl_q;
  assign bus.goal_r  = gr_q;
endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: serve, paddle returns, walls, goals, hold, reset.
module tb_ball_mover;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ball_mover_if bus();

  ball_mover dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, 32'(bus.ball_x), 32'(ex));
    chk({tag, "_y"}, 32'(bus.ball_y), 32'(ey));
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.serve      = 1'b0;
    bus.collide_l  = 1'b0;
    bus.collide_r  = 1'b0;
    bus.deflect    = '0;

    // Reset state
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    chk_pos("rst", 316, 236);
    chk("rst_in_play", 32'(bus.in_play), 0);
    chk("rst_goal_l", 32'(bus.goal_l), 0);
    chk("rst_goal_r", 32'(bus.goal_r), 0);

    // No motion while idle
    tick();
    chk_pos("idle_tick", 316, 236);

    // Serve rightward, three frames
    bus.serve = 1'b1;
    cyc();
    bus.serve = 1'b0;
    chk("serve_in_play", 32'(bus.in_play), 1);
    chk_pos("serve", 316, 236);
    tick(); chk_pos("f1", 320, 236);
    tick(); chk_pos("f2", 324, 236);
    tick(); chk_pos("f3", 328, 236);

    // Right paddle hit, up, magnitude 40 -> dy clamped to 8; held for 5 frames
    bus.collide_r = 1'b1;
    bus.deflect   = 10'h228;
    cyc();
    chk_pos("hit_r_no_tick", 328, 236);
    tick(); chk_pos("hit_r_f1", 324, 228);
    repeat (4) tick();
    chk_pos("hit_r_held", 308, 196);
    bus.collide_r = 1'b0;
    cyc();
    bus.collide_r = 1'b1;
    cyc();
    tick(); chk_pos("hit_r_reedge_ignored", 304, 188);
    bus.collide_r = 1'b0;

    // Top wall bounce
    repeat (23) tick();
    chk_pos("pre_top", 212, 4);
    tick(); chk_pos("top_clamp", 208, 0);
    tick(); chk_pos("top_bounce", 204, 8);

    // Left miss
    repeat (50) tick();
    chk_pos("pre_miss_l", 4, 408);
    chk("pre_miss_goal_r", 32'(bus.goal_r), 0);
    tick();
    chk_pos("miss_l", 0, 416);
    chk("miss_l_goal_r", 32'(bus.goal_r), 1);
    chk("miss_l_goal_l", 32'(bus.goal_l), 0);
    chk("miss_l_in_play", 32'(bus.in_play), 0);
    cyc();
    chk("goal_r_one_clk", 32'(bus.goal_r), 0);

    // Hold: frozen for 60 frames, serve ignored meanwhile
    bus.serve = 1'b1;
    repeat (59) tick();
    chk_pos("hold_frozen", 0, 416);
    chk("hold_serve_ignored", 32'(bus.in_play), 0);
    bus.serve = 1'b0;
    tick();
    chk_pos("hold_recentre", 316, 236);
    chk("hold_idle", 32'(bus.in_play), 0);

    // Serve goes toward the conceder (left)
    bus.serve = 1'b1;
    cyc();
    bus.serve = 1'b0;
    tick(); chk_pos("serve_left", 312, 236);

    // Left paddle hit coinciding with frame tick: down, mag 20 -> dy 5
    bus.collide_l  = 1'b1;
    bus.deflect    = 10'h014;
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    bus.collide_l  = 1'b0;
    chk_pos("hit_l_same_tick", 316, 241);

    // Bottom wall bounce
    repeat (46) tick();
    chk_pos("pre_bottom", 500, 471);
    tick(); chk_pos("bottom_clamp", 504, 472);
    tick(); chk_pos("bottom_bounce", 508, 467);

    // Right miss
    repeat (30) tick();
    chk_pos("pre_miss_r", 628, 317);
    tick();
    chk_pos("miss_r", 632, 312);
    chk("miss_r_goal_l", 32'(bus.goal_l), 1);
    chk("miss_r_goal_r", 32'(bus.goal_r), 0);
    chk("miss_r_in_play", 32'(bus.in_play), 0);

    // Fresh game: six flat returns with no motion in between
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    bus.serve = 1'b1;
    cyc();
    bus.serve   = 1'b0;
    bus.deflect = 10'h000;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) bus.collide_r = 1'b1;
      else            bus.collide_l = 1'b1;
      cyc();
      bus.collide_r = 1'b0;
      bus.collide_l = 1'b0;
      cyc();
    end
    tick();
`ifdef BALL_SPEEDUP_EN
    chk_pos("six_hits_dx", 324, 236);
`else
    chk_pos("six_hits_dx", 320, 236);
`endif
    chk("six_hits_in_play", 32'(bus.in_play), 1);

    // Reset mid-play
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk_pos("midrst", 316, 236);
    chk("midrst_in_play", 32'(bus.in_play), 0);
    chk("midrst_goal_l", 32'(bus.goal_l), 0);
    chk("midrst_goal_r", 32'(bus.goal_r), 0);
    tick();
    chk_pos("midrst_idle", 316, 236);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
